alu_op_sequencer: RTL and testbench

Command-side initiator for the 8-op combinational ALU.
- Accepts instructions over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU operand/select inputs from registers, captures the ALU result and zero flag, and writes the result back to the register file.
- Returns each result over a valid/ready response channel.
- Sits between the instruction source (test host or microcontroller front end) and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 20 ++
 rtl/alu_op_sequencer_if.sv | 36 +++
 rtl/alu.sv | 32 +++
 rtl/alu_seq_regfile.sv | 35 +++
 rtl/alu_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 263 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU op sequencer: ALU select codes and FSM states.
package alu_seq_pkg;

    // ALU select encoding; must stay bit-identical to the attached ALU.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction and response channels of the ALU op sequencer.
interface alu_op_sequencer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RAW   = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_ld;
    logic [2:0]       cmd_op;
    logic [RAW-1:0]   cmd_rd;
    logic [RAW-1:0]   cmd_rs1;
    logic [RAW-1:0]   cmd_rs2;
    logic [WIDTH-1:0] cmd_imm;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic [RAW-1:0]   rsp_rd;

    // Instruction source / response consumer side.
    modport master (
        output cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_zero, rsp_rd,
        output rsp_ready
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_ld, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_zero, rsp_rd,
        input  rsp_ready
    );
endinterface

// File: rtl/alu.sv
// 8-op combinational ALU driven by the sequencer.
module alu
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [2:0]       sel_i,
    output logic [WIDTH-1:0] y_o,
    output logic             zero_o
);

    // Result select; arithmetic wraps, shifts act on A only.
    always_comb begin
        y_o = '0;
        unique case (sel_i)
            OP_ADD: y_o = a_i + b_i;
            OP_SUB: y_o = a_i - b_i;
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_XOR: y_o = a_i ^ b_i;
            OP_SHL: y_o = a_i << 1;
            OP_SHR: y_o = a_i >> 1;
            OP_SLT: y_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            default: y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);

endmodule

// File: rtl/alu_seq_regfile.sv
// NREG x WIDTH register file: two asynchronous read ports, one synchronous
// write port, synchronous active-low clear.
module alu_seq_regfile #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4,
    parameter int unsigned RAW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [RAW-1:0]   waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [RAW-1:0]   raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [RAW-1:0]   raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] regs_q [NREG];

    // Clear on reset, otherwise write one register when enabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for the combinational ALU: accepts instructions,
// drives registered operands, writes results back and returns responses.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4,
    parameter int unsigned RAW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_sequencer_if.slave bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [RAW-1:0]   rd_q, rd_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic [RAW-1:0]   rsp_rd_q, rsp_rd_d;

    logic             cmd_ready;
    logic             rsp_valid;
    logic             rf_we;
    logic [RAW-1:0]   rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic [WIDTH-1:0] rf_rdata_a;
    logic [WIDTH-1:0] rf_rdata_b;

    alu_seq_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .RAW   (RAW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata),
        .raddr_a_i (bus.cmd_rs1),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (bus.cmd_rs2),
        .rdata_b_o (rf_rdata_b)
    );

    // Next-state, handshake and register-file write control.
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rd_d       = rd_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_rd_d   = rsp_rd_q;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = rd_q;
        rf_wdata   = alu_out;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (bus.cmd_ld) begin
                        rf_we      = 1'b1;
                        rf_waddr   = bus.cmd_rd;
                        rf_wdata   = bus.cmd_imm;
                        rsp_data_d = bus.cmd_imm;
                        rsp_zero_d = (bus.cmd_imm == '0);
                        rsp_rd_d   = bus.cmd_rd;
                        state_d    = RESP;
                    end else begin
                        alu_a_d   = rf_rdata_a;
                        alu_b_d   = rf_rdata_b;
                        alu_sel_d = bus.cmd_op;
                        rd_d      = bus.cmd_rd;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // ALU output has settled from the registered operands.
                rf_we      = 1'b1;
                rf_waddr   = rd_q;
                rf_wdata   = alu_out;
                rsp_data_d = alu_out;
                rsp_zero_d = alu_zero;
                rsp_rd_d   = rd_q;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rd_q       <= rd_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_rd_q   <= rsp_rd_d;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_sel       = alu_sel_q;
    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_rd    = rsp_rd_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with the 8-bit ALU attached.
module tb_alu_op_sequencer;

    localparam logic [2:0] T_ADD = 3'b000;
    localparam logic [2:0] T_SUB = 3'b001;
    localparam logic [2:0] T_AND = 3'b010;
    localparam logic [2:0] T_OR  = 3'b011;
    localparam logic [2:0] T_XOR = 3'b100;
    localparam logic [2:0] T_SHL = 3'b101;
    localparam logic [2:0] T_SHR = 3'b110;
    localparam logic [2:0] T_SLT = 3'b111;

    typedef struct {
        logic [7:0] data;
        logic       zero;
        logic [1:0] rd;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_sel;
    logic       alu_zero;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    logic [7:0] last_a = '0;
    logic [7:0] last_b = '0;
    logic [2:0] last_sel = '0;

    alu_op_sequencer_if #(.WIDTH(8), .RAW(2)) bus ();

    alu_op_sequencer #(.WIDTH(8), .NREG(4), .RAW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .alu_zero (alu_zero)
    );

    alu #(.WIDTH(8)) u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .sel_i  (alu_sel),
        .y_o    (alu_out),
        .zero_o (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " cmd_ready"}, bus.cmd_ready, 1);
    endtask

    // Issue one instruction, queue its expected response, check latency and
    // the ALU operand registers.
    task automatic send(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm,
                        input logic [7:0] ea, input logic [7:0] eb,
                        input logic [7:0] ed, input logic ez, input string tag);
        exp_t e;
        wait_ready(tag);
        bus.cmd_ld    = ld;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;
        e.data = ed;
        e.zero = ez;
        e.rd   = rd;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        if (ld) begin
            chk({tag, " valid@1"}, bus.rsp_valid, 1);
            chk({tag, " a hold"}, alu_a, last_a);
            chk({tag, " sel hold"}, alu_sel, last_sel);
        end else begin
            chk({tag, " valid@1"}, bus.rsp_valid, 0);
            chk({tag, " issue a"}, alu_a, ea);
            chk({tag, " issue b"}, alu_b, eb);
            chk({tag, " issue sel"}, alu_sel, op);
            last_a   = ea;
            last_b   = eb;
            last_sel = op;
            @(negedge clk);
            chk({tag, " valid@2"}, bus.rsp_valid, 1);
        end
    endtask

    // Read a register by OR-ing it with itself into itself.
    task automatic rdreg(input logic [1:0] r, input logic [7:0] v, input string tag);
        send(1'b0, T_OR, r, r, r, 8'h00, v, v, v, (v == 8'h00), tag);
    endtask

    // Monitor: every accepted response is compared against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got data %0h expected none", bus.rsp_data);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_zero", bus.rsp_zero, e.zero);
                    chk("rsp_rd", bus.rsp_rd, e.rd);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_ld    = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_rd    = '0;
        bus.cmd_rs1   = '0;
        bus.cmd_rs2   = '0;
        bus.cmd_imm   = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: reset state and first load
        @(negedge clk);
        chk("rst cmd_ready", bus.cmd_ready, 1);
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst alu_sel", alu_sel, 0);
        chk("rst alu_a", alu_a, 0);
        chk("rst alu_b", alu_b, 0);
        chk("rst rsp_data", bus.rsp_data, 0);
        send(1'b1, T_ADD, 2'd1, 2'd0, 2'd0, 8'h0F, 8'h00, 8'h00, 8'h0F, 1'b0, "ld r1");

        // 2: add and readback
        send(1'b1, T_ADD, 2'd2, 2'd0, 2'd0, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0, "ld r2");
        send(1'b0, T_ADD, 2'd3, 2'd1, 2'd2, 8'h00, 8'h0F, 8'h01, 8'h10, 1'b0, "add r3");
        rdreg(2'd3, 8'h10, "rd r3");

        // 3: wrap to zero, self-subtract
        send(1'b1, T_ADD, 2'd1, 2'd0, 2'd0, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, "ld r1 ff");
        send(1'b1, T_ADD, 2'd2, 2'd0, 2'd0, 8'h01, 8'h00, 8'h00, 8'h01, 1'b0, "ld r2 01");
        send(1'b0, T_ADD, 2'd0, 2'd1, 2'd2, 8'h00, 8'hFF, 8'h01, 8'h00, 1'b1, "add wrap");
        send(1'b0, T_SUB, 2'd0, 2'd2, 2'd2, 8'h00, 8'h01, 8'h01, 8'h00, 1'b1, "sub self");

        // 4: unsigned less-than with rd == rs1
        send(1'b1, T_ADD, 2'd1, 2'd0, 2'd0, 8'h03, 8'h00, 8'h00, 8'h03, 1'b0, "ld r1 03");
        send(1'b1, T_ADD, 2'd2, 2'd0, 2'd0, 8'h05, 8'h00, 8'h00, 8'h05, 1'b0, "ld r2 05");
        send(1'b0, T_SLT, 2'd1, 2'd1, 2'd2, 8'h00, 8'h03, 8'h05, 8'h01, 1'b0, "slt 3<5");
        send(1'b0, T_SLT, 2'd1, 2'd2, 2'd1, 8'h00, 8'h05, 8'h01, 8'h00, 1'b1, "slt 5<1");

        // remaining select codes
        send(1'b1, T_ADD, 2'd0, 2'd0, 2'd0, 8'hF0, 8'h00, 8'h00, 8'hF0, 1'b0, "ld r0 f0");
        send(1'b1, T_ADD, 2'd3, 2'd0, 2'd0, 8'h3C, 8'h00, 8'h00, 8'h3C, 1'b0, "ld r3 3c");
        send(1'b0, T_AND, 2'd2, 2'd0, 2'd3, 8'h00, 8'hF0, 8'h3C, 8'h30, 1'b0, "and");
        send(1'b0, T_OR,  2'd2, 2'd0, 2'd3, 8'h00, 8'hF0, 8'h3C, 8'hFC, 1'b0, "or");
        send(1'b0, T_XOR, 2'd2, 2'd0, 2'd3, 8'h00, 8'hF0, 8'h3C, 8'hCC, 1'b0, "xor");
        send(1'b0, T_SHR, 2'd2, 2'd0, 2'd3, 8'h00, 8'hF0, 8'h3C, 8'h78, 1'b0, "shr");
        send(1'b0, T_SUB, 2'd2, 2'd3, 2'd0, 8'h00, 8'h3C, 8'hF0, 8'h4C, 1'b0, "sub wrap");
        send(1'b0, T_SLT, 2'd2, 2'd3, 2'd0, 8'h00, 8'h3C, 8'hF0, 8'h01, 1'b0, "slt 3c<f0");

        // 5: backpressure on shl, ignored command in the stall window
        send(1'b1, T_ADD, 2'd2, 2'd0, 2'd0, 8'h81, 8'h00, 8'h00, 8'h81, 1'b0, "ld r2 81");
        wait_ready("pre bp");
        bus.rsp_ready = 1'b0;
        send(1'b0, T_SHL, 2'd0, 2'd2, 2'd2, 8'h00, 8'h81, 8'h81, 8'h02, 1'b0, "shl bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp rsp_valid", bus.rsp_valid, 1);
            chk("bp rsp_data", bus.rsp_data, 8'h02);
            chk("bp cmd_ready", bus.cmd_ready, 0);
            if (i == 1) begin
                bus.cmd_ld    = 1'b1;
                bus.cmd_rd    = 2'd0;
                bus.cmd_imm   = 8'h77;
                bus.cmd_valid = 1'b1;
            end
            if (i == 3) bus.cmd_valid = 1'b0;
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        rdreg(2'd0, 8'h02, "rd r0 after bp");

        // 6: reset during ISSUE discards the command and clears registers
        send(1'b1, T_ADD, 2'd1, 2'd0, 2'd0, 8'hAA, 8'h00, 8'h00, 8'hAA, 1'b0, "ld r1 aa");
        send(1'b1, T_ADD, 2'd2, 2'd0, 2'd0, 8'h55, 8'h00, 8'h00, 8'h55, 1'b0, "ld r2 55");
        wait_ready("xor");
        bus.cmd_ld    = 1'b0;
        bus.cmd_op    = T_XOR;
        bus.cmd_rd    = 2'd3;
        bus.cmd_rs1   = 2'd1;
        bus.cmd_rs2   = 2'd2;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("xor issue a", alu_a, 8'hAA);
        chk("xor issue b", alu_b, 8'h55);
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_a   = '0;
        last_b   = '0;
        last_sel = '0;
        @(negedge clk);
        chk("post-rst cmd_ready", bus.cmd_ready, 1);
        chk("post-rst alu_a", alu_a, 0);
        chk("post-rst alu_sel", alu_sel, 0);
        for (int i = 0; i < 3; i++) begin
            chk("post-rst rsp_valid", bus.rsp_valid, 0);
            @(negedge clk);
        end
        rdreg(2'd0, 8'h00, "rd r0 clr");
        rdreg(2'd1, 8'h00, "rd r1 clr");
        rdreg(2'd2, 8'h00, "rd r2 clr");
        rdreg(2'd3, 8'h00, "rd r3 clr");

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drain", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
